// File: rtl/ila_capture_controller.sv
// ila_capture_controller
//   Sequencer for the ILA circular capture buffer. Arms a capture, drives
//   the external RAM write port, waits until every location has been
//   written once, then accepts a trigger. After a programmable holdoff it
//   freezes the buffer and reads it back oldest-to-newest through a
//   ready-gated read port.
//
//   Optional build macro: ILA_TRIG_ADDR_EN adds o_trig_addr (address of
//   the trigger sample, latched on the trigger cycle, cleared on arm).
//
// Ports
//   clk, reset                       clock, async active-high reset
//   i_arm                            start a new capture (ignored in READ)
//   i_trigger                        trigger qualifier, honoured in PRIMED
//   i_holdoff[HOLDOFF_WIDTH]         post-trigger write count
//   i_rd_start                       begin readout from DONE
//   i_rd_ready                       consumer accepts a read issue
//   o_wr_en, o_waddr                 RAM write port
//   o_ren, o_raddr                   RAM read port
//   o_rvalid, o_rlast                read data valid (o_ren + 1), final beat
//   o_primed, o_triggered, o_stopped status flags
//   o_busy                           capture or readout in progress
module ila_capture_controller #(
  parameter int ADDR_WIDTH    = 10,
  parameter int HOLDOFF_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_arm,
  input  logic                     i_trigger,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic                     i_rd_start,
  input  logic                     i_rd_ready,
  output logic                     o_wr_en,
  output logic [ADDR_WIDTH-1:0]    o_waddr,
  output logic                     o_ren,
  output logic [ADDR_WIDTH-1:0]    o_raddr,
  output logic                     o_rvalid,
  output logic                     o_rlast,
  output logic                     o_primed,
  output logic                     o_triggered,
  output logic                     o_stopped,
`ifdef ILA_TRIG_ADDR_EN
  output logic [ADDR_WIDTH-1:0]    o_trig_addr,
`endif
  output logic                     o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PRIMED, S_HOLDOFF, S_DONE, S_READ
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]    wptr;
  logic [ADDR_WIDTH-1:0]    fill_cnt;
  logic [ADDR_WIDTH-1:0]    rd_cnt;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt;

  // Arm is honoured everywhere except READ and always beats other requests.
  logic arm_go;
  logic fill_last;
  logic trig_hit;
  logic rd_go;
  logic rd_last;

  assign arm_go    = i_arm && (state != S_READ);
  assign fill_last = (state == S_FILL) && (fill_cnt == '1);
  assign trig_hit  = (state == S_PRIMED) && i_trigger && !arm_go;
  assign rd_go     = (state == S_DONE) && i_rd_start && !arm_go;
  assign rd_last   = o_ren && (rd_cnt == '1);

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state;
    if (arm_go) begin
      state_nxt = S_FILL;
    end else begin
      case (state)
        S_FILL:    if (fill_last) state_nxt = S_PRIMED;
        S_PRIMED:  if (i_trigger)
                     state_nxt = (i_holdoff == '0) ? S_DONE : S_HOLDOFF;
        S_HOLDOFF: if (hold_cnt == HOLDOFF_WIDTH'(1)) state_nxt = S_DONE;
        S_DONE:    if (i_rd_start) state_nxt = S_READ;
        S_READ:    if (rd_last) state_nxt = S_DONE;
        default:   state_nxt = state;
      endcase
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    o_wr_en = 1'b0;
    o_ren   = 1'b0;
    o_busy  = 1'b0;
    case (state)
      S_FILL, S_PRIMED, S_HOLDOFF: begin
        o_wr_en = 1'b1;
        o_busy  = 1'b1;
      end
      S_READ: begin
        o_ren  = i_rd_ready;
        o_busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_waddr = wptr;

  // ---------------- datapath ----------------
  // The write pointer is never cleared by arm, so the buffer stays circular
  // across captures; only reset returns it to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      fill_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      if (o_wr_en) wptr <= wptr + ADDR_WIDTH'(1);
      if (arm_go)                  fill_cnt <= '0;
      else if (state == S_FILL)    fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
      if (trig_hit)                hold_cnt <= i_holdoff;
      else if (state == S_HOLDOFF) hold_cnt <= hold_cnt - HOLDOFF_WIDTH'(1);
    end
  end

  // Readout starts at the write pointer, which after the holdoff points at
  // the oldest sample still in the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_raddr  <= '0;
      rd_cnt   <= '0;
      o_rvalid <= 1'b0;
      o_rlast  <= 1'b0;
    end else begin
      if (rd_go) begin
        o_raddr <= wptr;
        rd_cnt  <= '0;
      end else if (o_ren) begin
        o_raddr <= o_raddr + ADDR_WIDTH'(1);
        rd_cnt  <= rd_cnt + ADDR_WIDTH'(1);
      end
      o_rvalid <= o_ren;
      o_rlast  <= rd_last;
    end
  end

  // Status flags. A trigger coinciding with the last fill write is not seen
  // because trig_hit only qualifies in PRIMED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_primed    <= 1'b0;
      o_triggered <= 1'b0;
      o_stopped   <= 1'b0;
    end else if (arm_go) begin
      o_primed    <= 1'b0;
      o_triggered <= 1'b0;
      o_stopped   <= 1'b0;
    end else begin
      if (fill_last) o_primed    <= 1'b1;
      if (trig_hit)  o_triggered <= 1'b1;
      if ((state == S_PRIMED || state == S_HOLDOFF) && state_nxt == S_DONE)
        o_stopped <= 1'b1;
    end
  end

`ifdef ILA_TRIG_ADDR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         o_trig_addr <= '0;
    else if (arm_go)   o_trig_addr <= '0;
    else if (trig_hit) o_trig_addr <= wptr;
  end
`endif

endmodule

// File: tb/tb_ila_capture_controller.sv
module tb_ila_capture_controller;
  localparam int AW    = 4;
  localparam int HW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_arm = 1'b0, i_trigger = 1'b0, i_rd_start = 1'b0, i_rd_ready = 1'b0;
  logic [HW-1:0] i_holdoff = '0;
  logic          o_wr_en, o_ren, o_rvalid, o_rlast, o_primed, o_triggered, o_stopped, o_busy;
  logic [AW-1:0] o_waddr, o_raddr;
`ifdef ILA_TRIG_ADDR_EN
  logic [AW-1:0] o_trig_addr;
`endif

  ila_capture_controller #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) dut (
    .clk(clk), .reset(reset), .i_arm(i_arm), .i_trigger(i_trigger),
    .i_holdoff(i_holdoff), .i_rd_start(i_rd_start), .i_rd_ready(i_rd_ready),
    .o_wr_en(o_wr_en), .o_waddr(o_waddr), .o_ren(o_ren), .o_raddr(o_raddr),
    .o_rvalid(o_rvalid), .o_rlast(o_rlast), .o_primed(o_primed),
    .o_triggered(o_triggered), .o_stopped(o_stopped),
`ifdef ILA_TRIG_ADDR_EN
    .o_trig_addr(o_trig_addr),
`endif
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  wire [2*AW+7:0] outs = {o_wr_en, o_waddr, o_ren, o_raddr, o_rvalid, o_rlast,
                          o_primed, o_triggered, o_stopped, o_busy};

  int checks = 0;
  int errors = 0;

  // Model of the external RAM plus transaction logs. Every write stores a
  // global sequence stamp, so a correct readout must return the last DEPTH
  // stamps in increasing order.
  int cyc_n = 0;
  int stamp = 0;
  int mem[DEPTH];
  int wr_addr_q[$];
  int ren_cyc_q[$], rd_addr_q[$], rd_stamp_q[$];
  int rv_cyc_q[$];
  bit rv_last_q[$];

  always @(negedge clk) begin
    cyc_n++;
    if (!reset) begin
      if (o_ren) begin
        ren_cyc_q.push_back(cyc_n);
        rd_addr_q.push_back(int'(o_raddr));
        rd_stamp_q.push_back(mem[o_raddr]);
      end
      if (o_rvalid) begin
        rv_cyc_q.push_back(cyc_n);
        rv_last_q.push_back(o_rlast);
      end
      if (o_wr_en) begin
        mem[o_waddr] = stamp;
        stamp++;
        wr_addr_q.push_back(int'(o_waddr));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rd_logs();
    ren_cyc_q.delete(); rd_addr_q.delete(); rd_stamp_q.delete();
    rv_cyc_q.delete();  rv_last_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL idle_after_reset: got %h want 0", outs);
    end
  endtask

  // Full capture: arm, fill (with ignored triggers), trigger at address ta,
  // holdoff h, then readout with the chosen ready pattern. abort_after >= 0
  // asserts reset after that many read issues.
  task automatic test_capture(input int ta, input int h, input int mode,
                              input int abort_after, input string nm);
    int n, st_end, bad, rv_before;
    i_arm = 1'b1; cyc(); i_arm = 1'b0;
    wr_addr_q.delete();
    checks++;
    if (o_wr_en !== 1'b1 || o_primed !== 1'b0 || o_triggered !== 1'b0 ||
        o_stopped !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s arm: wr_en=%b primed=%b trig=%b stop=%b busy=%b want 1,0,0,0,1",
               nm, o_wr_en, o_primed, o_triggered, o_stopped, o_busy);
    end

    // Triggers on write 5 and on the final fill write must be ignored.
    n = 0;
    while (o_primed !== 1'b1 && n < 40) begin
      i_trigger = (n == 4 || n == DEPTH - 1);
      cyc(); n++;
    end
    i_trigger = 1'b0;
    checks++;
    if (n != DEPTH || wr_addr_q.size() != DEPTH) begin
      errors++;
      $display("FAIL %s prime_count: cycles=%0d writes=%0d want %0d", nm, n, wr_addr_q.size(), DEPTH);
    end
    checks++;
    if (o_triggered !== 1'b0 || o_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL %s fill_trigger_ignored: trig=%b wr_en=%b want 0,1", nm, o_triggered, o_wr_en);
    end
    bad = -1;
    for (int i = 1; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] != (wr_addr_q[i-1] + 1) % DEPTH && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s waddr_wrap: idx %0d addr %0d after %0d", nm, bad, wr_addr_q[bad], wr_addr_q[bad-1]);
    end

    n = 0;
    while (o_waddr !== AW'(ta) && n < 40) begin cyc(); n++; end
    i_holdoff = HW'(h);
    i_trigger = 1'b1;
    cyc();
    i_trigger = 1'b0;
    wr_addr_q.delete();
    n = 0;
    while (o_wr_en === 1'b1 && n < h + 5) begin cyc(); n++; end
    checks++;
    if (n != h || wr_addr_q.size() != h ||
        (h > 0 && wr_addr_q[wr_addr_q.size()-1] != (ta + h) % DEPTH)) begin
      errors++;
      $display("FAIL %s holdoff: cycles=%0d writes=%0d want %0d last=%0d", nm, n,
               wr_addr_q.size(), h, (ta + h) % DEPTH);
    end
    checks++;
    if (o_stopped !== 1'b1 || o_triggered !== 1'b1 || o_busy !== 1'b0 ||
        o_waddr !== AW'((ta + h + 1) % DEPTH)) begin
      errors++;
      $display("FAIL %s done: stop=%b trig=%b busy=%b waddr=%0d want 1,1,0,%0d", nm,
               o_stopped, o_triggered, o_busy, o_waddr, (ta + h + 1) % DEPTH);
    end
`ifdef ILA_TRIG_ADDR_EN
    checks++;
    if (o_trig_addr !== AW'(ta)) begin
      errors++; $display("FAIL %s trig_addr: got %0d want %0d", nm, o_trig_addr, ta);
    end
`endif

    // Readout.
    st_end = stamp;
    clear_rd_logs();
    i_rd_start = 1'b1; cyc(); i_rd_start = 1'b0;
    n = 0;
    while (o_busy === 1'b1 && n < 200) begin
      case (mode)
        0:       i_rd_ready = 1'b1;
        1:       i_rd_ready = (n % 2 == 0);
        default: i_rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (abort_after >= 0 && ren_cyc_q.size() == abort_after) begin
        // Mid-cycle asynchronous reset while an issue is being presented.
        i_rd_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== '0) begin
          errors++; $display("FAIL %s async_reset: got %h want 0", nm, outs);
        end
        i_rd_ready = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        rv_before = rv_cyc_q.size();
        cyc(); cyc(); cyc();
        checks++;
        if (rv_cyc_q.size() != rv_before || ren_cyc_q.size() != abort_after || outs !== '0) begin
          errors++;
          $display("FAIL %s post_reset_quiet: rvalids=%0d/%0d issues=%0d outs=%h", nm,
                   rv_cyc_q.size(), rv_before, ren_cyc_q.size(), outs);
        end
        return;
      end
      cyc(); n++;
    end
    i_rd_ready = 1'b0;
    cyc();
    checks++;
    if (n >= 200 || rd_addr_q.size() != DEPTH || rv_cyc_q.size() != DEPTH) begin
      errors++;
      $display("FAIL %s read_count: issues=%0d rvalids=%0d want %0d (timeout=%0d)", nm,
               rd_addr_q.size(), rv_cyc_q.size(), DEPTH, n >= 200);
    end else begin
      bad = -1;
      for (int i = 0; i < DEPTH; i++)
        if (rd_addr_q[i] != (ta + h + 1 + i) % DEPTH && bad < 0) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s raddr: beat %0d got %0d want %0d", nm, bad, rd_addr_q[bad], (ta + h + 1 + bad) % DEPTH);
      end
      bad = -1;
      for (int i = 0; i < DEPTH; i++)
        if (rd_stamp_q[i] != st_end - DEPTH + i && bad < 0) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s oldest_first: beat %0d stamp %0d want %0d", nm, bad, rd_stamp_q[bad], st_end - DEPTH + bad);
      end
      bad = -1;
      for (int i = 0; i < DEPTH; i++)
        if ((rv_cyc_q[i] != ren_cyc_q[i] + 1 || rv_last_q[i] != (i == DEPTH - 1)) && bad < 0) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s rvalid_rlast: beat %0d rv_cyc=%0d ren_cyc=%0d last=%b", nm, bad,
                 rv_cyc_q[bad], ren_cyc_q[bad], rv_last_q[bad]);
      end
    end
    checks++;
    if (o_stopped !== 1'b1 || o_busy !== 1'b0 || o_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_done: stop=%b busy=%b rvalid=%b want 1,0,0", nm, o_stopped, o_busy, o_rvalid);
    end
  endtask

  // Arm ignored in READ; arm beats rd_start in DONE. Assumes DUT is in DONE.
  task automatic test_arm_rules();
    int n;
    clear_rd_logs();
    i_rd_start = 1'b1; cyc(); i_rd_start = 1'b0;
    i_rd_ready = 1'b1; cyc(); cyc();
    i_arm = 1'b1; cyc(); i_arm = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_wr_en !== 1'b0 || o_stopped !== 1'b1) begin
      errors++;
      $display("FAIL arm_in_read: busy=%b wr_en=%b stop=%b want 1,0,1", o_busy, o_wr_en, o_stopped);
    end
    n = 0;
    while (o_busy === 1'b1 && n < 40) begin cyc(); n++; end
    i_rd_ready = 1'b0;
    cyc();
    checks++;
    if (rv_cyc_q.size() != DEPTH) begin
      errors++; $display("FAIL arm_in_read_count: rvalids=%0d want %0d", rv_cyc_q.size(), DEPTH);
    end
    i_arm = 1'b1; i_rd_start = 1'b1; cyc(); i_arm = 1'b0; i_rd_start = 1'b0;
    checks++;
    if (o_wr_en !== 1'b1 || o_ren !== 1'b0 || o_stopped !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL arm_beats_rd_start: wr_en=%b ren=%b stop=%b busy=%b want 1,0,0,1",
               o_wr_en, o_ren, o_stopped, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_capture(3, 4, 0, -1, "ta3_h4");
    test_capture(9, 0, 0, -1, "ta9_h0");
    test_capture(5, 2, 1, -1, "ready_toggle");
    test_capture(12, 20, 0, -1, "holdoff_wrap");
    test_arm_rules();
    test_capture(6, 3, 0, -1, "rearm_from_fill");
    test_capture(1, 5, 0, 6, "reset_mid_read");
    test_capture(3, 4, 2, -1, "after_reset");
    for (int k = 0; k < 6; k++)
      test_capture($urandom_range(0, DEPTH - 1), $urandom_range(0, 40),
                   $urandom_range(0, 2), -1, "random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ila_capture_controller.md
Name: ila_capture_controller

Overview:
Sequencing controller for the internal logic analyzer's circular capture buffer. It arms capture, generates write enable and write address, waits for the buffer to be primed, and accepts a trigger. It then counts a programmable holdoff, stops writing, and reads the buffer back oldest-to-newest over a ready-gated read port. The capture RAM is external; this block drives only its address and enable lines.

Parameters:
ADDR_WIDTH, 10, buffer address width; depth = 2**ADDR_WIDTH
HOLDOFF_WIDTH, 20, width of holdoff count

Ports:
clk  in  1  single clock domain
reset  in  1  asynchronous, active-high reset
i_arm  in  1  pulse; start a new capture from IDLE or DONE
i_trigger  in  1  trigger qualifier, sampled every cycle
i_holdoff  in  HOLDOFF_WIDTH  post-trigger write count, latched on trigger
i_rd_start  in  1  pulse; begin readout from DONE
i_rd_ready  in  1  consumer can accept a read issue this cycle
o_wr_en  out  1  RAM write enable
o_waddr  out  ADDR_WIDTH  RAM write address
o_ren  out  1  RAM read enable
o_raddr  out  ADDR_WIDTH  RAM read address
o_rvalid  out  1  RAM read data valid; o_ren delayed 1 cycle
o_rlast  out  1  qualifies final o_rvalid of readout
o_primed  out  1  buffer fully written since arm
o_triggered  out  1  trigger accepted
o_stopped  out  1  capture halted; buffer frozen
o_busy  out  1  state != IDLE and state != DONE

Behaviour:
- Reset: state=IDLE; every output 0; write pointer, read counter and holdoff counter 0. Async assert; deassert is synchronous to clk.
- States: IDLE, FILL, PRIMED, HOLDOFF, DONE, READ.
- IDLE/DONE + i_arm -> FILL. Clears o_primed, o_triggered, o_stopped and the fill counter. The write pointer is not reset; it continues circularly.
- o_wr_en=1 in FILL, PRIMED and HOLDOFF; 0 elsewhere. o_waddr = write pointer. The pointer increments mod 2**ADDR_WIDTH on every write.
- FILL: count writes. After 2**ADDR_WIDTH writes, o_primed=1 (registered) and -> PRIMED. Triggers in FILL are ignored and not remembered.
- PRIMED + i_trigger at cycle T: the write at T occurs (trigger sample address = Ta). Latch H=i_holdoff, set o_triggered=1, -> HOLDOFF.
- HOLDOFF: perform exactly H further writes, addresses Ta+1..Ta+H. If H=0, go straight to DONE; o_wr_en=0 from T+1. Otherwise o_wr_en=0 from T+H+1.
- DONE entry: o_stopped=1. The write pointer holds (Ta+H+1), which is the oldest sample.
- H >= 2**ADDR_WIDTH is legal; it overwrites the trigger sample and the buffer then holds only post-trigger data.
- DONE + i_rd_start -> READ. o_raddr starts at the write pointer; read counter=0.
- READ: o_ren = i_rd_ready. On each o_ren cycle, o_raddr increments mod depth and the counter increments.
- o_rvalid is o_ren registered. o_rlast is asserted with the 2**ADDR_WIDTH-th o_rvalid. After the last issue -> DONE (o_stopped stays 1), so the buffer can be re-read.
- i_arm in READ is ignored.
- i_arm and i_rd_start in the same cycle in DONE: i_arm wins.
- i_arm in FILL, PRIMED or HOLDOFF restarts FILL: clear flags and fill count.
- i_trigger in the same cycle as the final FILL write is ignored; priming completes first.
- Reset mid-READ or mid-HOLDOFF aborts immediately; o_rvalid is not emitted for an in-flight issue.

Optional Feature:
ILA_TRIG_ADDR_EN: adds output o_trig_addr [ADDR_WIDTH], which is Ta latched on the trigger cycle, held until the next arm, and reset to 0. Without the macro the port and its register are absent, and behaviour is otherwise identical.

Test Plan:
- ADDR_WIDTH=4, reset, arm -> o_wr_en high; o_primed rises after exactly 16 writes; o_waddr wraps 15->0.
- Trigger pulsed during FILL (write 5) -> ignored; o_triggered stays 0; first trigger after primed is accepted.
- Trigger at Ta=3 with i_holdoff=4 -> last write address 7, o_stopped=1; readout addresses 8,9..15,0..7; o_rlast on the 16th o_rvalid.
- i_holdoff=0 -> o_wr_en low the cycle after trigger; readout begins at Ta+1.
- i_rd_ready toggled 1,0,1,0 during READ -> o_raddr advances only on ready cycles; exactly 16 o_rvalid with 1-cycle latency.
- Reset asserted mid-READ (after 6 issues) -> all outputs 0 asynchronously; no further o_rvalid; a re-arm then works normally.
